// File: rtl/strip_trig_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | strip_trig_pkg : shared word layout and FSM encoding for the strip     |
// | trigger link (transmitter and receiver).  Rev 1.0                      |
// +-----------------------------------------------------------------------+
package strip_trig_pkg;

   localparam int BCID_FIELD_W = 12;
   localparam int BAND_FIELD_W = 8;
   localparam int PHI_FIELD_W  = 5;
   localparam int FRAME_CYCLES = 13;
   localparam int WORD_W       = 26;
   localparam int BIT_CNT_W    = 4;

   localparam int PHI_LSB  = 20;
   localparam int BAND_LSB = 12;
   localparam int BCID_LSB = 0;
   localparam int PAR_BIT  = 25;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DRAIN = 2'd2
   } rx_state_t;

   // Parity bit that makes the total count of ones in the full word even.
   function automatic logic even_parity(input logic [WORD_W-2:0] data);
      return ^data;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sat_counter : saturating event counter with synchronous clear.         |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/strip_trigger_receiver.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | strip_trigger_receiver : deserializes 2-lane trigger frames, checks    |
// | length/parity, delivers fields on valid/ready.  Rev 1.0                |
// +-----------------------------------------------------------------------+
module strip_trigger_receiver
   import strip_trig_pkg::*;
#(
   parameter int BCID_W    = BCID_FIELD_W,
   parameter int BAND_ID_W = BAND_FIELD_W,
   parameter int PHI_ID_W  = PHI_FIELD_W,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 trig_en,
   input  logic                 trig_d0,
   input  logic                 trig_d1,
   input  logic                 out_ready,
   input  logic                 cnt_clear,
   output logic                 out_valid,
   output logic [BCID_W-1:0]    out_bcid,
   output logic [BAND_ID_W-1:0] out_band_id,
   output logic [PHI_ID_W-1:0]  out_phi_id,
   output logic                 len_err,
   output logic                 parity_err,
   output logic [CNT_W-1:0]     frame_cnt,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [CNT_W-1:0]     ovf_cnt
);

   localparam logic [BIT_CNT_W-1:0] LAST_CNT = BIT_CNT_W'(FRAME_CYCLES);

   rx_state_t              state, state_nxt;
   logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
   logic [WORD_W-1:0]      shreg;
   logic                   shift_en;
   logic                   frame_done;
   logic                   len_evt;
   logic                   parity_ok;
   logic                   good_evt;
   logic                   par_evt;
   logic                   busy;
   logic                   load;
   logic                   drop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shift_en    = 1'b0;
      frame_done  = 1'b0;
      len_evt     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (trig_en) begin
               shift_en    = 1'b1;
               bit_cnt_nxt = BIT_CNT_W'(1);
               state_nxt   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (trig_en) begin
               if (bit_cnt == LAST_CNT) begin
                  len_evt     = 1'b1;
                  bit_cnt_nxt = '0;
                  state_nxt   = ST_DRAIN;
               end else begin
                  shift_en    = 1'b1;
                  bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
               end
            end else begin
               if (bit_cnt == LAST_CNT) begin
                  frame_done = 1'b1;
               end else begin
                  len_evt = 1'b1;
               end
               bit_cnt_nxt = '0;
               state_nxt   = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (!trig_en) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            bit_cnt_nxt = '0;
            state_nxt   = ST_IDLE;
         end
      endcase
   end

   // MSB-first: the pair from frame cycle 0 ends up in bits [25:24].
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg <= '0;
      end else if (shift_en) begin
         shreg <= {shreg[WORD_W-3:0], trig_d1, trig_d0};
      end
   end

   assign parity_ok = (shreg[PAR_BIT] == even_parity(shreg[PAR_BIT-1:0]));
   assign good_evt  = frame_done && parity_ok;
   assign par_evt   = frame_done && !parity_ok;
   assign busy      = out_valid && !out_ready;
   assign load      = good_evt && !busy;
   assign drop      = good_evt && busy;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid   <= 1'b0;
         out_bcid    <= '0;
         out_band_id <= '0;
         out_phi_id  <= '0;
         len_err     <= 1'b0;
         parity_err  <= 1'b0;
      end else begin
         len_err    <= len_evt;
         parity_err <= par_evt;
         if (load) begin
            out_valid   <= 1'b1;
            out_bcid    <= shreg[BCID_LSB +: BCID_W];
            out_band_id <= shreg[BAND_LSB +: BAND_ID_W];
            out_phi_id  <= shreg[PHI_LSB +: PHI_ID_W];
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (good_evt),
      .clr   (cnt_clear),
      .count (frame_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (len_evt | par_evt),
      .clr   (cnt_clear),
      .count (err_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (drop),
      .clr   (cnt_clear),
      .count (ovf_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_strip_trigger_receiver.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_strip_trigger_receiver : scoreboard bench for the trigger receiver. |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_strip_trigger_receiver;

   // Narrow counters keep the saturation scenario short.
   localparam int CW   = 8;
   localparam int CMAX = (1 << CW) - 1;

   typedef enum int {EV_NONE, EV_GOOD, EV_PAR, EV_LEN} ev_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          trig_en = 1'b0;
   logic          trig_d0 = 1'b0;
   logic          trig_d1 = 1'b0;
   logic          out_ready = 1'b0;
   logic          cnt_clear = 1'b0;
   logic          out_valid;
   logic [11:0]   out_bcid;
   logic [7:0]    out_band_id;
   logic [4:0]    out_phi_id;
   logic          len_err;
   logic          parity_err;
   logic [CW-1:0] frame_cnt;
   logic [CW-1:0] err_cnt;
   logic [CW-1:0] ovf_cnt;

   strip_trigger_receiver #(.CNT_W(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .trig_en     (trig_en),
      .trig_d0     (trig_d0),
      .trig_d1     (trig_d1),
      .out_ready   (out_ready),
      .cnt_clear   (cnt_clear),
      .out_valid   (out_valid),
      .out_bcid    (out_bcid),
      .out_band_id (out_band_id),
      .out_phi_id  (out_phi_id),
      .len_err     (len_err),
      .parity_err  (parity_err),
      .frame_cnt   (frame_cnt),
      .err_cnt     (err_cnt),
      .ovf_cnt     (ovf_cnt)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_pass = 0;
   int          rmode = 0;
   ev_t         ev = EV_NONE;
   logic [25:0] ev_word = '0;

   // Reference model state: one-deep output holding slot plus event counts.
   logic [25:0] exp_q[$];
   logic        m_valid = 1'b0;
   logic        exp_len = 1'b0;
   logic        exp_par = 1'b0;
   logic        m_busy;
   logic [25:0] m_w;
   int          m_frame = 0;
   int          m_err = 0;
   int          m_ovf = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int sat(input int v);
      return (v < CMAX) ? v + 1 : v;
   endfunction

   function automatic logic [25:0] mk(input logic [11:0] bcid, input logic [7:0] band,
                                      input logic [4:0] phi, input logic bad);
      return {(^{phi, band, bcid}) ^ bad, phi, band, bcid};
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         check("reset_fields", {out_valid, len_err, parity_err, out_phi_id, out_band_id, out_bcid}, 32'd0);
         check("reset_counters", {frame_cnt, err_cnt, ovf_cnt}, 32'd0);
         m_valid = 1'b0; exp_len = 1'b0; exp_par = 1'b0;
         m_frame = 0; m_err = 0; m_ovf = 0;
         exp_q.delete();
      end else begin
         check("flags_valid_len_par", {out_valid, len_err, parity_err}, {m_valid, exp_len, exp_par});
         check("counters_frame_err_ovf", {frame_cnt, err_cnt, ovf_cnt},
               {m_frame[CW-1:0], m_err[CW-1:0], m_ovf[CW-1:0]});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL xfer_unexpected: got transfer of %0h expected none at %0t",
                        {out_phi_id, out_band_id, out_bcid}, $time);
            end else begin
               m_w = exp_q.pop_front();
               check("xfer_fields", {out_phi_id, out_band_id, out_bcid}, {7'd0, m_w[24:0]});
            end
         end
         // What the coming rising edge does.
         m_busy  = m_valid && !out_ready;
         if (m_valid && out_ready) m_valid = 1'b0;
         exp_len = 1'b0;
         exp_par = 1'b0;
         case (ev)
            EV_GOOD: begin
               m_frame = sat(m_frame);
               if (m_busy) m_ovf = sat(m_ovf);
               else begin
                  exp_q.push_back(ev_word);
                  m_valid = 1'b1;
               end
            end
            EV_PAR: begin exp_par = 1'b1; m_err = sat(m_err); end
            EV_LEN: begin exp_len = 1'b1; m_err = sat(m_err); end
            default: ;
         endcase
         if (cnt_clear) begin
            m_frame = 0; m_err = 0; m_ovf = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      ev = EV_NONE;
      if (rmode == 2) out_ready = 1'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear_cnt();
      tick();
      cnt_clear = 1'b1;
      tick();
      cnt_clear = 1'b0;
   endtask

   // len high cycles, then gap low cycles (gap >= 1; >= 2 when rdy_end/clr_end).
   task automatic send(input int len, input logic [25:0] w, input int gap,
                       input bit rdy_end, input bit clr_end);
      for (int k = 0; k < len; k++) begin
         tick();
         trig_en = 1'b1;
         if (k < 13) begin
            trig_d1 = w[25-2*k];
            trig_d0 = w[24-2*k];
         end else begin
            trig_d1 = 1'($urandom);
            trig_d0 = 1'($urandom);
         end
         if (k == 13) ev = EV_LEN;
      end
      tick();
      trig_en = 1'b0;
      trig_d1 = 1'b0;
      trig_d0 = 1'b0;
      ev_word = w;
      if (len < 13) ev = EV_LEN;
      else if (len == 13) ev = (^w) ? EV_PAR : EV_GOOD;
      if (rdy_end) out_ready = 1'b1;
      if (clr_end) cnt_clear = 1'b1;
      for (int g = 1; g < gap; g++) begin
         tick();
         if (g == 1) begin
            if (rdy_end) out_ready = 1'b0;
            if (clr_end) cnt_clear = 1'b0;
         end
      end
   endtask

   initial begin
      idle(3);
      reset = 1'b1;
      idle(2);

      // Single good frame, always ready.
      out_ready = 1'b1;
      send(13, mk(12'hABC, 8'h5A, 5'h13, 1'b0), 2, 1'b0, 1'b0);
      idle(4);
      check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
      check("t1_err_cnt", 32'(err_cnt), 32'd0);

      // Flipped parity bit.
      clear_cnt();
      send(13, mk(12'hABC, 8'h5A, 5'h13, 1'b1), 2, 1'b0, 1'b0);
      idle(4);
      check("t2_err_cnt", 32'(err_cnt), 32'd1);
      check("t2_frame_cnt", 32'(frame_cnt), 32'd0);

      // Short then long frame, then recovery.
      clear_cnt();
      send(10, mk(12'h111, 8'h22, 5'h03, 1'b0), 2, 1'b0, 1'b0);
      send(16, mk(12'h222, 8'h33, 5'h04, 1'b0), 2, 1'b0, 1'b0);
      check("t3_err_cnt", 32'(err_cnt), 32'd2);
      send(13, mk(12'h5C3, 8'hE1, 5'h1F, 1'b0), 2, 1'b0, 1'b0);
      idle(4);
      check("t3_frame_cnt", 32'(frame_cnt), 32'd1);

      // Overflow: three back-to-back frames with downstream stalled.
      out_ready = 1'b0;
      clear_cnt();
      send(13, mk(12'd1, 8'h10, 5'h01, 1'b0), 1, 1'b0, 1'b0);
      send(13, mk(12'd2, 8'h20, 5'h02, 1'b0), 1, 1'b0, 1'b0);
      send(13, mk(12'd3, 8'h30, 5'h03, 1'b0), 1, 1'b0, 1'b0);
      idle(3);
      check("t4_held_bcid", 32'(out_bcid), 32'd1);
      check("t4_ovf_cnt", 32'(ovf_cnt), 32'd2);
      check("t4_frame_cnt", 32'(frame_cnt), 32'd3);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      idle(2);
      check("t4_valid_after_xfer", 32'(out_valid), 32'd0);

      // New word lands in the same cycle the held word is consumed.
      clear_cnt();
      send(13, mk(12'd1, 8'h44, 5'h05, 1'b0), 2, 1'b0, 1'b0);
      send(13, mk(12'd2, 8'h55, 5'h06, 1'b0), 2, 1'b1, 1'b0);
      idle(2);
      check("t5_valid", 32'(out_valid), 32'd1);
      check("t5_bcid", 32'(out_bcid), 32'd2);
      check("t5_ovf_cnt", 32'(ovf_cnt), 32'd0);
      out_ready = 1'b1;
      idle(2);

      // Randomized traffic with random backpressure and length/parity faults.
      rmode = 2;
      clear_cnt();
      for (int i = 0; i < 150; i++) begin
         int len;
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 13;
         send(len, mk(12'($urandom), 8'($urandom), 5'($urandom), ($urandom_range(0, 5) == 0)),
              int'($urandom_range(1, 3)), 1'b0, 1'b0);
      end
      rmode = 0;
      out_ready = 1'b1;
      idle(4);

      // Error counter saturation, then clear winning over an error.
      clear_cnt();
      for (int i = 0; i < CMAX + 5; i++) send(2, 26'd0, 1, 1'b0, 1'b0);
      idle(2);
      check("t6_err_saturated", 32'(err_cnt), 32'(CMAX));
      send(2, 26'd0, 2, 1'b0, 1'b1);
      idle(2);
      check("t6_err_cleared", 32'(err_cnt), 32'd0);

      // Reset in the middle of a frame.
      send(13, mk(12'h0F0, 8'h0F, 5'h0A, 1'b0), 2, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         tick();
         trig_en = 1'b1;
         trig_d1 = 1'($urandom);
         trig_d0 = 1'($urandom);
      end
      tick();
      reset = 1'b0;
      trig_en = 1'b0;
      #1;
      check("t7_async_reset_outputs",
            {out_valid, len_err, parity_err, out_phi_id, out_band_id, out_bcid}, 32'd0);
      idle(3);
      reset = 1'b1;
      idle(20);
      check("t7_no_err_after_reset", 32'(err_cnt), 32'd0);

      // Reset released while trig_en is already high: flagged as short frame.
      tick();
      reset = 1'b0;
      trig_en = 1'b1;
      idle(2);
      reset = 1'b1;
      idle(5);
      trig_en = 1'b0;
      ev = EV_LEN;
      idle(3);
      check("t8_err_cnt", 32'(err_cnt), 32'd1);

      send(13, mk(12'hFED, 8'hC3, 5'h11, 1'b0), 2, 1'b0, 1'b0);
      idle(20);
      check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/strip_trigger_receiver.md
Name: strip_trigger_receiver

Overview:
Link-side decoder for the strip trigger serial link. It deserializes frames framed by trig_en on two data lanes (d1/d0). It checks frame length and parity and delivers {bcid, band_id, phi_id} on a valid/ready output. It provides saturating frame, error and overflow counters. It is used on the receiving board and as a loopback checker for the trigger transmitter; inputs are already single-ended and sampled in clk (link bit clock, 320 MHz).

Parameters:
BCID_W, 12, BCID field width
BAND_ID_W, 8, band id field width
PHI_ID_W, 5, phi id field width
CNT_W, 16, width of each statistics counter

Ports:
clk  input  1  link bit clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
trig_en  input  1  frame enable; high for exactly 13 consecutive cycles per frame
trig_d0  input  1  lane 0 data (even word bits)
trig_d1  input  1  lane 1 data (odd word bits)
out_ready  input  1  downstream accepts decoded word
cnt_clear  input  1  synchronous clear of all counters
out_valid  output  1  decoded word available
out_bcid  output  BCID_W  decoded BCID
out_band_id  output  BAND_ID_W  decoded band id
out_phi_id  output  PHI_ID_W  decoded phi id
len_err  output  1  one-cycle pulse on frame length error
parity_err  output  1  one-cycle pulse on parity error
frame_cnt  output  CNT_W  good frames delivered or dropped by overflow
err_cnt  output  CNT_W  length plus parity errors
ovf_cnt  output  CNT_W  good frames dropped because output busy

Behaviour:
- Word (26 b): [25] even parity over [24:0]; [24:20] phi_id; [19:12] band_id; [11:0] bcid. The total count of ones in the 26 bits is even.
- Frame cycle k (k = 0..12, counted from the first trig_en=1 cycle): d1 = word[25-2k], d0 = word[24-2k]. MSB first.
- A gap of at least 1 trig_en=0 cycle is required between frames.
- FSM states: IDLE, SHIFT, DRAIN.
  - IDLE: trig_en=1 → shift in {d1,d0}, bit counter = 1, go to SHIFT.
  - SHIFT, trig_en=1, counter < 13 → shift, counter += 1.
  - SHIFT, trig_en=1, counter == 13 → len_err pulse, go to DRAIN.
  - SHIFT, trig_en=0, counter == 13 → frame complete, run parity check, go to IDLE.
  - SHIFT, trig_en=0, counter < 13 → len_err pulse, go to IDLE; partial word discarded.
  - DRAIN: wait for trig_en=0, then go to IDLE. No capture while in DRAIN.
- Frame-complete event occurs in the cycle trig_en is sampled low (cycle 13).
  - Parity bad → parity_err pulse in the following cycle; word discarded.
  - Parity good → out_valid high from cycle 14 with the fields registered.
- Latency: first frame bit at cycle 0 → out_valid at cycle 14.
- Output handshake:
  - out_valid and the fields hold until out_valid && out_ready; out_valid then drops next cycle unless a new word is loaded that same cycle.
  - New good word while out_valid && !out_ready → new word dropped, ovf_cnt += 1, held word unchanged.
  - New good word while out_valid && out_ready in the same cycle → held word consumed, new word loaded, out_valid stays high.
- Counters:
  - Increment by 1 per event; saturate at all-ones.
  - frame_cnt counts every good-parity, correct-length frame, including dropped ones.
  - err_cnt counts len_err + parity_err.
  - cnt_clear has priority over increment in the same cycle.
- len_err and parity_err never assert in the same cycle for one frame.
- Reset (reset=0, async): FSM = IDLE, bit counter = 0, out_valid = 0, all out_* fields = 0, len_err = parity_err = 0, all counters = 0. Reset mid-frame aborts the frame with no error pulse. After reset release, a frame is accepted only on a fresh trig_en=1 seen in IDLE; if trig_en is already high at release, the remaining cycles are treated as a short/long frame and flagged.

Decomposition:
- Shared package strip_trig_pkg holds:
  - field widths
  - FRAME_CYCLES = 13
  - WORD_W = 26
  - field bit offsets (PHI_LSB = 20, BAND_LSB = 12, BCID_LSB = 0, PAR_BIT = 25)
  - FSM state enum
  - helper function for even parity
- The transmitter uses the same package.
- One sub-module: sat_counter (CNT_W parameter; inc, clr inputs), instantiated three times.

Test Plan:
- Good frame, bcid=12'hABC, band_id=8'h5A, phi_id=5'h13, parity 0, out_ready=1 → out_valid one cycle at cycle 14 with those fields; frame_cnt=1, err_cnt=0.
- Same frame with parity bit flipped to 1 → parity_err pulse; no out_valid; err_cnt=1, frame_cnt=0.
- trig_en high 10 cycles, then high 16 cycles → two len_err pulses; DRAIN is held until trig_en falls; err_cnt=2, no out_valid; a following good frame decodes correctly.
- out_ready=0, three back-to-back good frames (1-cycle gaps), bcid 1/2/3 → out_bcid stays 1; ovf_cnt=2, frame_cnt=3. Then out_ready=1 → one transfer, out_valid low.
- out_valid held with bcid=1; a new good frame bcid=2 completes in the same cycle out_ready=1 → out_valid stays high, out_bcid=2, ovf_cnt=0.
- Force err_cnt to 16'hFFFF via repeated errors, then one more error → stays 16'hFFFF. cnt_clear together with an error → 0. Assert reset mid-frame → all outputs 0 and no error pulse.
